sca_group_ctrl: RTL and testbench
=================================

# sca_group_ctrl

Parametrised successor to the fixed A/B/C/D/E channel sampling controller. It drives the sample enables of `N_BANKS` fast SCA banks plus the slow bank. Banks are sampled in groups of 1, 2 or all banks, selected by `smode`. On each trigger the active group stops and the next group takes over, giving multi-hit capture without wraparound loss. A serial shift register then reads out the trigger count and the per-bank stop counters.

## Interface
Parameters:
- `N_BANKS`, 4: number of fast banks; power of two, ≥4.
- `CNT_W`, 8: width of the coarse sample counter and of each stop counter.
- `TRIG_W`, 8: width of the trigger counter.
- Derived: `SR_W = TRIG_W + N_BANKS*CNT_W`.

Ports:
- `clk`  in  1  the single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous return to INIT; same effect as `rst`.
- `start`  in  1  pulse; begin or resume sampling.
- `stop`  in  1  pulse; halt sampling.
- `trigger`  in  1  pulse; close the active group.
- `smode`  in  2  group size: 01=1 bank, 10=2 banks, 11=N_BANKS, 00 treated as 01.
- `slow_en`  in  1  also sample the slow bank.
- `readout_req`  in  1  pulse; load the shift register.
- `read_shift`  in  1  advance the shift register by one bit.
- `bank_en`  out  N_BANKS  fast bank sample enables.
- `slow_sample`  out  1  slow bank sample enable.
- `state`  out  2  current state: INIT=0, STOPPED=1, SAMPLING=2, READOUT=3.
- `trig_count`  out  TRIG_W  number of accepted triggers.
- `all_full`  out  1  every group has been closed.
- `sout`  out  1  serial data out; LSB first.
- `readout_done`  out  1  one-cycle pulse after the last bit.

## Operation
All outputs are registered.

Reset (`rst`, or `clear` on an edge):
- State INIT; `bank_en`=0, `slow_sample`=0, `sout`=0, `readout_done`=0.
- `cnt`, `trig_count`, all `stop_cnt[i]`, `full`, group index `g` and shift register all 0.
- `clear` has the highest priority of all inputs.

Group definition:
- Group size G comes from `smode`, latched together with `slow_en` when `start` is accepted in INIT.
- NG = N_BANKS/G groups; group g covers banks g*G .. g*G+G-1.
- `smode` and `slow_en` are ignored at every other time.

INIT:
- `start` -> SAMPLING with g=0.

SAMPLING:
- `bank_en` has the bits of group g set.
- `slow_sample` = latched `slow_en`.
- `cnt` increments each cycle and wraps from 2^CNT_W-1 to 0.
- `trigger`:
  - Every bank of group g loads `stop_cnt` with the current (pre-increment) `cnt`.
  - `full[g]` is set.
  - `trig_count` increments, saturating at all-ones.
  - If g<NG-1: g increments, and `bank_en` moves to the new group on the next cycle, with no gap cycle.
  - If g=NG-1: -> STOPPED, `all_full`=1.
- `stop` -> STOPPED; `cnt` is held.
- `trigger` and `stop` in the same cycle: the trigger is processed first, then -> STOPPED.

STOPPED:
- `bank_en`=0, `slow_sample`=0.
- `start` with `all_full`=0 resumes SAMPLING on the same g; `cnt` continues from its held value.
- `start` with `all_full`=1 is ignored.
- `readout_req` -> READOUT. If `readout_req` and `start` arrive together, readout wins.

READOUT:
- Shift register loads {stop_cnt[N_BANKS-1], …, stop_cnt[0], trig_count}, so `sout` first presents bit 0 of `trig_count`.
- Each `read_shift` shifts right by one and fills with 0.
- On the SR_W-th shift: -> STOPPED, `readout_done` pulses for 1 cycle, and captured data is retained.
- `start`, `stop`, `trigger` and `readout_req` are ignored.

Outside SAMPLING:
- `trigger` is ignored and not counted.
- `cnt` does not change.

## Timing
- Every transition takes effect one cycle after the input edge.
- `start` in cycle t: `bank_en` is valid in t+1, and `cnt`=0 in t+1 when starting from INIT.
- A trigger in cycle t captures the `cnt` value of cycle t; the next group's `bank_en` is valid in t+1.
- `sout` is valid one cycle after `readout_req`, and one cycle after each `read_shift`.
- Asynchronous `rst` forces all outputs to their reset values immediately; release is synchronous to `clk`.

## Test plan
All scenarios use N_BANKS=4, CNT_W=8, TRIG_W=8.
- Reset: assert `rst` mid-SAMPLING -> `bank_en`=0000, `state`=0, `sout`=0, `trig_count`=0 immediately.
- smode=01: `start`, then triggers on SAMPLING cycles 3, 10, 20, 40 -> `bank_en` steps 0001→0010→0100→1000→0000; `stop_cnt`=3,10,20,40; `all_full`=1; state STOPPED; a further `start` is ignored.
- smode=10 with `slow_en`=1: `bank_en`=0011 and `slow_sample`=1; trigger at cycle 5 -> 1100; trigger at cycle 9 -> STOPPED; `stop_cnt`={9,9,5,5}; `trig_count`=2.
- Wrap and resume: smode=11; run 200 cycles, `stop`, `start`, run 100 more cycles, trigger -> all four `stop_cnt`=44, i.e. 300 mod 256.
- Simultaneous `trigger`+`stop` at cycle 7 with smode=01 -> `stop_cnt[0]`=7; state STOPPED; g=1; a later `start` gives `bank_en`=0010.
- Readout after the smode=01 case: `readout_req` then 40 `read_shift` pulses -> bits are 4 (8b LSB-first), 3, 10, 20, 40; `readout_done` pulses once; state STOPPED. Asserting `clear` partway through -> INIT with `sout`=0.

Source files
------------

// File: rtl/sca_group_ctrl.sv
// Group-wise sample-enable controller for N_BANKS fast SCA banks plus a slow bank.
// Captures per-bank stop counters on triggers and reads them out serially, LSB first.
module sca_group_ctrl #(
   parameter int unsigned N_BANKS = 4,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned TRIG_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                start,
   input  logic                stop,
   input  logic                trigger,
   input  logic [1:0]          smode,
   input  logic                slow_en,
   input  logic                readout_req,
   input  logic                read_shift,
   output logic [N_BANKS-1:0]  bank_en,
   output logic                slow_sample,
   output logic [1:0]          state,
   output logic [TRIG_W-1:0]   trig_count,
   output logic                all_full,
   output logic                sout,
   output logic                readout_done
);
   localparam int unsigned SR_W = TRIG_W + N_BANKS*CNT_W;
   localparam int unsigned GW   = $clog2(N_BANKS);
   localparam int unsigned LW   = $clog2(GW+1);
   localparam int unsigned SW   = $clog2(SR_W+1);

   typedef enum logic [1:0] {
      INIT     = 2'd0,
      STOPPED  = 2'd1,
      SAMPLING = 2'd2,
      READOUT  = 2'd3
   } state_t;

   state_t                         st, st_n;
   logic [CNT_W-1:0]               cnt, cnt_n;
   logic [TRIG_W-1:0]              trig_n;
   logic [N_BANKS-1:0][CNT_W-1:0]  stop_cnt, stop_cnt_n;
   logic [N_BANKS-1:0]             full, full_n, bank_en_n, grp;
   logic [GW-1:0]                  g, g_n, last_g;
   logic [LW-1:0]                  glog, glog_n;
   logic                           slow_lat, slow_lat_n, slow_n, all_full_n, done_n;
   logic [SR_W-1:0]                sr, sr_n;
   logic [SW-1:0]                  scnt, scnt_n;

   assign state = st;
   assign sout  = sr[0];

   // Bank i belongs to group gi when its index divided by the group size equals gi.
   function automatic logic [N_BANKS-1:0] grp_mask(input logic [GW-1:0] gi, input logic [LW-1:0] gl);
      logic [N_BANKS-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < N_BANKS; i++) m[i] = ((GW'(i) >> gl) == gi);
      return m;
   endfunction

   assign last_g = GW'((N_BANKS >> glog) - 32'd1);

   always_comb begin
      st_n       = st;
      cnt_n      = cnt;
      trig_n     = trig_count;
      stop_cnt_n = stop_cnt;
      full_n     = full;
      g_n        = g;
      glog_n     = glog;
      slow_lat_n = slow_lat;
      all_full_n = all_full;
      sr_n       = sr;
      scnt_n     = scnt;
      done_n     = 1'b0;
      grp        = grp_mask(g, glog);
      if (clear) begin
         st_n       = INIT;
         cnt_n      = '0;
         trig_n     = '0;
         stop_cnt_n = '0;
         full_n     = '0;
         g_n        = '0;
         glog_n     = '0;
         slow_lat_n = 1'b0;
         all_full_n = 1'b0;
         sr_n       = '0;
         scnt_n     = '0;
      end else begin
         case (st)
            INIT: begin
               if (start) begin
                  st_n       = SAMPLING;
                  g_n        = '0;
                  slow_lat_n = slow_en;
                  case (smode)
                     2'b11:   glog_n = LW'(GW);
                     2'b10:   glog_n = LW'(1);
                     default: glog_n = '0;
                  endcase
               end
            end
            SAMPLING: begin
               // Trigger is handled before stop so a coincident pair still closes the group.
               if (trigger) begin
                  for (int unsigned i = 0; i < N_BANKS; i++)
                     if (grp[i]) stop_cnt_n[i] = cnt;
                  full_n[g] = 1'b1;
                  if (trig_count != '1) trig_n = trig_count + 1'b1;
                  if (g == last_g) begin
                     all_full_n = 1'b1;
                     st_n       = STOPPED;
                  end else begin
                     g_n = g + 1'b1;
                  end
               end
               if (stop) st_n = STOPPED;
               if (st_n == SAMPLING) cnt_n = cnt + 1'b1;
            end
            STOPPED: begin
               if (readout_req) begin
                  st_n   = READOUT;
                  sr_n   = {stop_cnt, trig_count};
                  scnt_n = '0;
               end else if (start && !all_full) begin
                  st_n = SAMPLING;
               end
            end
            READOUT: begin
               if (read_shift) begin
                  sr_n   = sr >> 1;
                  scnt_n = scnt + 1'b1;
                  if (scnt == SW'(SR_W-1)) begin
                     st_n   = STOPPED;
                     done_n = 1'b1;
                  end
               end
            end
            default: st_n = INIT;
         endcase
      end
      bank_en_n = (st_n == SAMPLING) ? grp_mask(g_n, glog_n) : '0;
      slow_n    = (st_n == SAMPLING) && slow_lat_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st           <= INIT;
         cnt          <= '0;
         trig_count   <= '0;
         stop_cnt     <= '0;
         full         <= '0;
         g            <= '0;
         glog         <= '0;
         slow_lat     <= 1'b0;
         all_full     <= 1'b0;
         sr           <= '0;
         scnt         <= '0;
         readout_done <= 1'b0;
         bank_en      <= '0;
         slow_sample  <= 1'b0;
      end else begin
         st           <= st_n;
         cnt          <= cnt_n;
         trig_count   <= trig_n;
         stop_cnt     <= stop_cnt_n;
         full         <= full_n;
         g            <= g_n;
         glog         <= glog_n;
         slow_lat     <= slow_lat_n;
         all_full     <= all_full_n;
         sr           <= sr_n;
         scnt         <= scnt_n;
         readout_done <= done_n;
         bank_en      <= bank_en_n;
         slow_sample  <= slow_n;
      end
   end
endmodule

// File: tb/tb_sca_group_ctrl.sv
// Bench for sca_group_ctrl: directed scenarios plus random traffic, checked every cycle
// against a behavioural model of groups, counters and the readout bit stream.
module tb_sca_group_ctrl;
   logic clk = 1'b0, rst = 1'b1, clear = 1'b0, start = 1'b0, stop = 1'b0, trigger = 1'b0;
   logic slow_en = 1'b0, readout_req = 1'b0, read_shift = 1'b0;
   logic [1:0] smode = 2'b00;
   logic [3:0] bank_en;
   logic       slow_sample, all_full, sout, readout_done;
   logic [1:0] state;
   logic [7:0] trig_count;
   logic [39:0] v;
   int n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   sca_group_ctrl #(.N_BANKS(4), .CNT_W(8), .TRIG_W(8)) dut (
      .clk(clk), .rst(rst), .clear(clear), .start(start), .stop(stop), .trigger(trigger),
      .smode(smode), .slow_en(slow_en), .readout_req(readout_req), .read_shift(read_shift),
      .bank_en(bank_en), .slow_sample(slow_sample), .state(state), .trig_count(trig_count),
      .all_full(all_full), .sout(sout), .readout_done(readout_done)
   );

   // Behavioural model: state as 0..3, group size G, group index g, plain integer counters.
   int m_state, m_cnt, m_g, m_G, m_trig, m_shifts;
   bit m_slow, m_allfull, m_done;
   int m_stop[4];
   logic [39:0] m_sr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task m_reset();
      m_state = 0; m_cnt = 0; m_g = 0; m_G = 1; m_trig = 0; m_shifts = 0;
      m_slow = 0; m_allfull = 0; m_done = 0; m_sr = '0;
      for (int i = 0; i < 4; i++) m_stop[i] = 0;
   endtask

   task model_step();
      bit leave;
      if (rst || clear) m_reset();
      else begin
         m_done = 0;
         case (m_state)
            0: if (start) begin
                  m_G = (smode == 2'b11) ? 4 : (smode == 2'b10) ? 2 : 1;
                  m_slow = slow_en; m_g = 0; m_state = 2;
               end
            2: begin
                  leave = 0;
                  if (trigger) begin
                     for (int b = m_g*m_G; b < m_g*m_G + m_G; b++) m_stop[b] = m_cnt;
                     m_trig = (m_trig == 255) ? 255 : m_trig + 1;
                     if (m_g == 4/m_G - 1) begin m_allfull = 1; leave = 1; end
                     else m_g++;
                  end
                  if (stop) leave = 1;
                  if (leave) m_state = 1; else m_cnt = (m_cnt + 1) % 256;
               end
            1: if (readout_req) begin
                  m_sr = {8'(m_stop[3]), 8'(m_stop[2]), 8'(m_stop[1]), 8'(m_stop[0]), 8'(m_trig)};
                  m_shifts = 0; m_state = 3;
               end else if (start && !m_allfull) m_state = 2;
            default: if (read_shift) begin
                  m_shifts++;
                  if (m_shifts == 40) begin m_state = 1; m_done = 1; end
               end
         endcase
      end
   endtask

   always @(posedge clk or posedge rst) model_step();

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      chk("bank_en", 64'(bank_en), (m_state == 2) ? 64'(((1 << m_G) - 1) << (m_g*m_G)) : 64'd0);
      chk("slow_sample", 64'(slow_sample), 64'((m_state == 2) && m_slow));
      chk("state", 64'(state), 64'(m_state));
      chk("trig_count", 64'(trig_count), 64'(m_trig));
      chk("all_full", 64'(all_full), 64'(m_allfull));
      chk("sout", 64'(sout), (m_state == 3) ? 64'(m_sr[m_shifts]) : 64'd0);
      chk("readout_done", 64'(readout_done), 64'(m_done));
   end

   task tick(); @(negedge clk); endtask
   task run(input int n); repeat (n) tick(); endtask
   task pulse_trig(); trigger = 1'b1; tick(); trigger = 1'b0; endtask
   task do_stop(); stop = 1'b1; tick(); stop = 1'b0; endtask
   task do_clear(); clear = 1'b1; tick(); clear = 1'b0; endtask
   task do_start(input logic [1:0] sm, input logic se);
      smode = sm; slow_en = se; start = 1'b1; tick(); start = 1'b0;
   endtask

   task read_all(output logic [39:0] bits);
      readout_req = 1'b1; tick(); readout_req = 1'b0;
      for (int k = 0; k < 40; k++) begin
         bits[k] = sout; read_shift = 1'b1; tick();
      end
      read_shift = 1'b0;
      chk("done_pulse", 64'(readout_done), 64'd1);
      chk("state_after_readout", 64'(state), 64'd1);
      tick();
      chk("done_single", 64'(readout_done), 64'd0);
   endtask

   initial begin
      m_reset();
      run(3);
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_bank_en", 64'(bank_en), 64'd0);
      rst = 1'b0; run(2);

      // smode=01: triggers at counts 3, 10, 20, 40
      do_start(2'b01, 1'b0);
      chk("g0_bank_en", 64'(bank_en), 64'd1);
      run(3);  pulse_trig(); chk("g1_bank_en", 64'(bank_en), 64'd2);
      run(6);  pulse_trig(); chk("g2_bank_en", 64'(bank_en), 64'd4);
      run(9);  pulse_trig(); chk("g3_bank_en", 64'(bank_en), 64'd8);
      run(19); pulse_trig();
      chk("full_bank_en", 64'(bank_en), 64'd0);
      chk("full_state", 64'(state), 64'd1);
      chk("full_flag", 64'(all_full), 64'd1);
      chk("full_trigs", 64'(trig_count), 64'd4);
      do_start(2'b01, 1'b0);
      chk("start_ignored_state", 64'(state), 64'd1);
      chk("start_ignored_bank", 64'(bank_en), 64'd0);
      read_all(v);
      chk("ro_trig", 64'(v[7:0]), 64'd4);
      chk("ro_stop0", 64'(v[15:8]), 64'd3);
      chk("ro_stop1", 64'(v[23:16]), 64'd10);
      chk("ro_stop2", 64'(v[31:24]), 64'd20);
      chk("ro_stop3", 64'(v[39:32]), 64'd40);

      // clear partway through a readout
      readout_req = 1'b1; tick(); readout_req = 1'b0;
      read_shift = 1'b1; run(5); read_shift = 1'b0;
      do_clear();
      chk("clear_state", 64'(state), 64'd0);
      chk("clear_sout", 64'(sout), 64'd0);

      // smode=10 with slow bank
      do_start(2'b10, 1'b1);
      chk("pair_bank_en", 64'(bank_en), 64'd3);
      chk("pair_slow", 64'(slow_sample), 64'd1);
      run(5); pulse_trig();
      chk("pair2_bank_en", 64'(bank_en), 64'd12);
      run(3); pulse_trig();
      chk("pair_state", 64'(state), 64'd1);
      chk("pair_trigs", 64'(trig_count), 64'd2);
      read_all(v);
      chk("pair_ro", 64'(v), 64'({8'd9, 8'd9, 8'd5, 8'd5, 8'd2}));
      do_clear();

      // counter wrap across stop/resume
      do_start(2'b11, 1'b0);
      run(200); do_stop();
      do_start(2'b01, 1'b0);
      chk("wrap_resume_bank", 64'(bank_en), 64'd15);
      run(100); pulse_trig();
      read_all(v);
      chk("wrap_ro", 64'(v), 64'({8'd44, 8'd44, 8'd44, 8'd44, 8'd1}));
      do_clear();

      // trigger and stop together
      do_start(2'b01, 1'b0);
      run(7);
      trigger = 1'b1; stop = 1'b1; tick(); trigger = 1'b0; stop = 1'b0;
      chk("ts_state", 64'(state), 64'd1);
      do_start(2'b01, 1'b0);
      chk("ts_next_group", 64'(bank_en), 64'd2);
      do_stop();
      read_all(v);
      chk("ts_stop0", 64'(v[15:8]), 64'd7);
      do_clear();

      // asynchronous reset mid-sampling
      do_start(2'b10, 1'b0);
      run(4); pulse_trig(); run(2);
      #2 rst = 1'b1;
      #1;
      chk("arst_bank_en", 64'(bank_en), 64'd0);
      chk("arst_state", 64'(state), 64'd0);
      chk("arst_sout", 64'(sout), 64'd0);
      chk("arst_trigs", 64'(trig_count), 64'd0);
      tick(); rst = 1'b0; tick();

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         clear       = ($urandom_range(0, 299) == 0);
         start       = ($urandom_range(0, 9) == 0);
         stop        = ($urandom_range(0, 29) == 0);
         trigger     = ($urandom_range(0, 7) == 0);
         smode       = 2'($urandom_range(0, 3));
         slow_en     = 1'($urandom_range(0, 1));
         readout_req = ($urandom_range(0, 19) == 0);
         read_shift  = ($urandom_range(0, 3) != 0);
         tick();
      end
      {clear, start, stop, trigger, readout_req, read_shift} = '0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
